max7219_frame_rx: RTL and testbench
===================================

Name: max7219_frame_rx

Overview:
- Synthesizable receive end of the MAX7219 serial link; the counterpart of max7219_if.
- Oversamples the MAX7219 CLK/DIN/LOAD pins in the system clock domain and deserialises a daisy-chained frame of G_NB_MATRIX 16-bit words.
- On each LOAD rising edge, latches the frame and streams it out word by word over a valid/ready handshake, with length-error and overrun flags.
- Used as a scoreboard front-end for max7219_scroller_ctrl benches and as a snoop block in FPGA debug builds.

Parameters:
- G_NB_MATRIX, 8: number of cascaded MAX7219 devices, i.e. words per frame, range 1..16.
- G_FRAME_CNT_WIDTH, 16: width of the captured-frame counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_max7219_clk  in  1  MAX7219 serial clock, asynchronous to clk.
- i_max7219_din  in  1  MAX7219 serial data, MSB first.
- i_max7219_load  in  1  MAX7219 LOAD/CS; a rising edge latches the frame.
- o_valid  out  1  output word valid.
- i_ready  in  1  consumer accepts the word when o_valid and i_ready are both 1.
- o_matrix_idx  out  max(1,$clog2(G_NB_MATRIX))  matrix index of the current word.
- o_word  out  16  full received word.
- o_addr  out  4  register address, o_word[11:8].
- o_data  out  8  register data, o_word[7:0].
- o_last  out  1  high with the word for idx G_NB_MATRIX-1.
- o_len_err  out  1  sticky per frame: bit count at LOAD was not 16*G_NB_MATRIX; valid for the whole EMIT phase.
- o_overrun  out  1  one-cycle pulse: a LOAD edge arrived during EMIT and that frame was dropped.
- o_busy  out  1  high in EMIT.
- o_frame_cnt  out  G_FRAME_CNT_WIDTH  number of frames accepted into the buffer; wraps.

Behaviour:
- Reset values: all outputs 0. Shift register, frame buffer, bit counter and synchroniser flops are 0. FSM is in IDLE.
- Input sampling: each pin passes a 2-FF synchroniser, then a registered-previous edge detector. Each pin level must be stable for at least 3 clk cycles; max7219_if with G_MAX_HALF_PERIOD >= 3 satisfies this.
- Shift: on a synchronised rising edge of MAX7219 CLK, the shift register (16*G_NB_MATRIX bits) shifts left and takes synchronised DIN into bit 0. DIN and CLK take the same synchroniser path, so they stay aligned.
- Bit counter: saturates at 16*G_NB_MATRIX+1 and is cleared on every LOAD rising edge.
- Word mapping at capture: matrix 0 is the device nearest DIN and holds the last 16 bits shifted (sr[15:0]). Matrix k holds sr[16k+15:16k].
- Simultaneous CLK and LOAD rising edges in the same cycle: the coincident bit is shifted in first and is included in the captured frame and in the length check. The counter then restarts at 0.
- FSM IDLE:
  - On a LOAD rising edge, copy the next-state shift register into the frame buffer.
  - Set o_len_err = (count != 16*G_NB_MATRIX).
  - Increment o_frame_cnt.
  - Set idx = 0 and go to EMIT.
  - Latency: o_valid rises 3 clk cycles after the first clk edge that samples i_max7219_load high.
- FSM EMIT:
  - o_valid = 1 and o_busy = 1.
  - Outputs are driven from the buffer at idx and held stable while i_ready = 0.
  - On accept with idx < G_NB_MATRIX-1, increment idx.
  - On accept with idx = G_NB_MATRIX-1 (o_last), go to IDLE and clear o_valid the next cycle.
  - Zero-bubble streaming: one word per cycle when i_ready is held high.
- LOAD rising edge in EMIT: the buffer is not touched and o_frame_cnt does not increment. o_overrun pulses 1 cycle. The shift register keeps running and the counter is cleared as usual.
- An acceptance cycle that coincides with a LOAD edge is handled in this order: the current handshake completes, and the LOAD edge counts as an overrun, because the FSM is still in EMIT that cycle.
- Shifting continues during EMIT; only the frame buffer is isolated.
- Reset asserted mid-operation: all state returns immediately to reset values and any in-progress frame is discarded.
- No LOAD edge ever: the block stays in IDLE and the counter saturates.

Decomposition:
- Package max7219_pkg contains:
  - C_MAX7219_WORD_WIDTH = 16.
  - Address and data field positions.
  - MAX7219 register address constants: NOOP 0x0, DIGIT0..7 0x1..0x8, DECODE 0x9, INTENSITY 0xA, SCAN_LIMIT 0xB, SHUTDOWN 0xC, DISPLAY_TEST 0xF.
  - The FSM enum t_rx_state {IDLE, EMIT}.
- Sub-module max7219_rx_sync: 2-FF synchroniser plus rising-edge detector, outputs level and rise. Instantiated three times.

Test Plan:
1. Drive max7219_if (G_MAX_HALF_PERIOD=4) with 8 words 0x0C01, 0x0B07, ..., 0x0F00 in daisy order, i_ready=1 -> 8 consecutive valids. idx0 = last word sent, idx7 = first word sent. o_last on idx7, o_len_err=0, o_frame_cnt=1.
2. Send 0x01A5 to all 8 matrices, holding i_ready=0 for 5 cycles on idx 3 -> outputs frozen at idx3, o_addr=0x1, o_data=0xA5; streaming resumes with no word lost or duplicated.
3. Pulse LOAD after only 120 bits -> frame emitted with o_len_err=1. Next correct 128-bit frame -> o_len_err=0.
4. Issue a second LOAD rising edge while idx=2 and i_ready=0 -> o_overrun 1-cycle pulse, o_frame_cnt unchanged, the remaining words are from the first frame.
5. Force a coincident CLK and LOAD rising edge on the 128th bit -> captured word 0 bit 0 equals that DIN value, o_len_err=0.
6. Assert rst_n=0 during EMIT at idx 4 -> the next cycle all outputs are 0 and the FSM is in IDLE. After release, the next full frame is received correctly with o_frame_cnt=1.

Source files
------------

// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - shared constants and types for the MAX7219 receive path
//
// Contents: word width, address/data field positions inside a 16-bit
// MAX7219 word, register address constants and the receiver FSM states.
package max7219_pkg;

    localparam int C_MAX7219_WORD_WIDTH = 16;

    // Field positions inside one 16-bit word (bits 15:12 are don't-care)
    localparam int C_ADDR_MSB = 11;
    localparam int C_ADDR_LSB = 8;
    localparam int C_DATA_MSB = 7;
    localparam int C_DATA_LSB = 0;

    // MAX7219 register addresses
    localparam logic [3:0] C_REG_NOOP         = 4'h0;
    localparam logic [3:0] C_REG_DIGIT0       = 4'h1;
    localparam logic [3:0] C_REG_DIGIT1       = 4'h2;
    localparam logic [3:0] C_REG_DIGIT2       = 4'h3;
    localparam logic [3:0] C_REG_DIGIT3       = 4'h4;
    localparam logic [3:0] C_REG_DIGIT4       = 4'h5;
    localparam logic [3:0] C_REG_DIGIT5       = 4'h6;
    localparam logic [3:0] C_REG_DIGIT6       = 4'h7;
    localparam logic [3:0] C_REG_DIGIT7       = 4'h8;
    localparam logic [3:0] C_REG_DECODE       = 4'h9;
    localparam logic [3:0] C_REG_INTENSITY    = 4'hA;
    localparam logic [3:0] C_REG_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] C_REG_SHUTDOWN     = 4'hC;
    localparam logic [3:0] C_REG_DISPLAY_TEST = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } t_rx_state;

endpackage

// File: rtl/max7219_rx_sync.sv
// rtl/max7219_rx_sync.sv - 2-FF synchroniser with registered rising-edge detector
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   pin        : asynchronous input pin
//   level      : synchronised level, aligned with rise (same pipeline depth)
//   rise       : one-cycle pulse on a synchronised rising edge
module max7219_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise
);

    logic meta;
    logic stab;
    logic prev;
    logic rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            stab   <= 1'b0;
            prev   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta   <= pin;
            stab   <= meta;
            prev   <= stab;
            rise_q <= stab & ~prev;
        end
    end

    // level is taken one stage after stab so that a data pin's level lines up
    // with the rise pulse of a clock pin passing through an identical instance.
    assign level = prev;
    assign rise  = rise_q;

endmodule

// File: rtl/max7219_frame_rx.sv
// rtl/max7219_frame_rx.sv - MAX7219 serial frame receiver with word-stream output
//
// Ports:
//   clk, rst_n          : system clock, asynchronous active-low reset
//   i_max7219_clk/din/load : MAX7219 serial pins, asynchronous to clk
//   o_valid, i_ready    : output word handshake
//   o_matrix_idx        : index of the current word (0 = device nearest DIN)
//   o_word/o_addr/o_data: full word and its address/data fields
//   o_last              : current word is for the last matrix
//   o_len_err           : captured frame bit count was not 16*G_NB_MATRIX
//   o_overrun           : pulse, a LOAD edge during EMIT was dropped
//   o_busy              : frame is being emitted
//   o_frame_cnt         : frames accepted into the buffer (wraps)
module max7219_frame_rx
    import max7219_pkg::*;
#(
    parameter int G_NB_MATRIX       = 8,
    parameter int G_FRAME_CNT_WIDTH = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        i_max7219_clk,
    input  logic                                        i_max7219_din,
    input  logic                                        i_max7219_load,
    output logic                                        o_valid,
    input  logic                                        i_ready,
    output logic [((G_NB_MATRIX > 1) ? $clog2(G_NB_MATRIX) : 1)-1:0] o_matrix_idx,
    output logic [15:0]                                 o_word,
    output logic [3:0]                                  o_addr,
    output logic [7:0]                                  o_data,
    output logic                                        o_last,
    output logic                                        o_len_err,
    output logic                                        o_overrun,
    output logic                                        o_busy,
    output logic [G_FRAME_CNT_WIDTH-1:0]                o_frame_cnt
);

    localparam int C_IDX_W      = (G_NB_MATRIX > 1) ? $clog2(G_NB_MATRIX) : 1;
    localparam int C_W          = C_MAX7219_WORD_WIDTH;
    localparam int C_FRAME_BITS = C_W * G_NB_MATRIX;
    localparam int C_CNT_W      = $clog2(C_FRAME_BITS + 2);

    localparam logic [C_CNT_W-1:0] C_CNT_FULL = C_CNT_W'(C_FRAME_BITS);
    localparam logic [C_CNT_W-1:0] C_CNT_SAT  = C_CNT_W'(C_FRAME_BITS + 1);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(G_NB_MATRIX - 1);

    // Synchronised pin events
    logic sclk_rise;
    logic din_level;
    logic load_rise;
    logic unused_sclk_level;
    logic unused_din_rise;
    logic unused_load_level;

    max7219_rx_sync u_sync_clk (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (i_max7219_clk),
        .level (unused_sclk_level),
        .rise  (sclk_rise)
    );

    max7219_rx_sync u_sync_din (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (i_max7219_din),
        .level (din_level),
        .rise  (unused_din_rise)
    );

    max7219_rx_sync u_sync_load (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (i_max7219_load),
        .level (unused_load_level),
        .rise  (load_rise)
    );

    // Deserialiser
    logic [C_FRAME_BITS-1:0] sr;
    logic [C_FRAME_BITS-1:0] sr_next;
    logic [C_CNT_W-1:0]      bit_cnt;
    logic [C_CNT_W-1:0]      bit_cnt_next;

    // sr_next / bit_cnt_next include a bit arriving in the same cycle as LOAD,
    // so capture and the length check both see it.
    always_comb begin
        sr_next      = sr;
        bit_cnt_next = bit_cnt;
        if (sclk_rise) begin
            sr_next = {sr[C_FRAME_BITS-2:0], din_level};
            if (bit_cnt != C_CNT_SAT) begin
                bit_cnt_next = bit_cnt + C_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            sr      <= sr_next;
            bit_cnt <= load_rise ? '0 : bit_cnt_next;
        end
    end

    // Frame FSM
    t_rx_state                state;
    t_rx_state                state_next;
    logic [C_IDX_W-1:0]       idx;
    logic [C_IDX_W-1:0]       idx_next;
    logic                     capture;
    logic                     overrun_next;

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        capture      = 1'b0;
        overrun_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_rise) begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                // A LOAD edge while emitting is dropped; the handshake in the
                // same cycle still completes normally.
                if (load_rise) begin
                    overrun_next = 1'b1;
                end
                if (i_ready) begin
                    if (idx == C_IDX_LAST) begin
                        state_next = IDLE;
                    end else begin
                        idx_next = idx + C_IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Frame buffer and per-frame status
    logic [C_FRAME_BITS-1:0]      frame_buf;
    logic                         len_err;
    logic                         overrun;
    logic [G_FRAME_CNT_WIDTH-1:0] frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_buf <= '0;
            len_err   <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            overrun <= overrun_next;
            if (capture) begin
                frame_buf <= sr_next;
                len_err   <= (bit_cnt_next != C_CNT_FULL);
                frame_cnt <= frame_cnt + G_FRAME_CNT_WIDTH'(1);
            end
        end
    end

    // Output mapping: matrix k holds sr[16k+15:16k]
    assign o_valid      = (state == EMIT);
    assign o_busy       = (state == EMIT);
    assign o_matrix_idx = idx;
    assign o_word       = frame_buf[int'(idx) * C_W +: C_W];
    assign o_addr       = o_word[C_ADDR_MSB:C_ADDR_LSB];
    assign o_data       = o_word[C_DATA_MSB:C_DATA_LSB];
    assign o_last       = (state == EMIT) && (idx == C_IDX_LAST);
    assign o_len_err    = len_err;
    assign o_overrun    = overrun;
    assign o_frame_cnt  = frame_cnt;

endmodule

// File: tb/tb_max7219_frame_rx.sv
// tb/tb_max7219_frame_rx.sv - self-checking bench for max7219_frame_rx
module tb_max7219_frame_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk;
    logic        sdin;
    logic        sload;
    logic        i_ready;
    logic        o_valid;
    logic [2:0]  o_matrix_idx;
    logic [15:0] o_word;
    logic [3:0]  o_addr;
    logic [7:0]  o_data;
    logic        o_last;
    logic        o_len_err;
    logic        o_overrun;
    logic        o_busy;
    logic [15:0] o_frame_cnt;

    max7219_frame_rx #(
        .G_NB_MATRIX       (8),
        .G_FRAME_CNT_WIDTH (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_max7219_clk  (sclk),
        .i_max7219_din  (sdin),
        .i_max7219_load (sload),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_matrix_idx   (o_matrix_idx),
        .o_word         (o_word),
        .o_addr         (o_addr),
        .o_data         (o_data),
        .o_last         (o_last),
        .o_len_err      (o_len_err),
        .o_overrun      (o_overrun),
        .o_busy         (o_busy),
        .o_frame_cnt    (o_frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic [2:0]  idx;
        logic        last;
        logic        len_err;
    } exp_t;

    typedef struct {
        logic [15:0] w [8];
        int          nbits;
        logic        len_err;
        int          hold;
    } fvec_t;

    exp_t        sb [$];
    exp_t        e;
    fvec_t       vecs [4];
    logic [127:0] tb_sr;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovr_seen = 0;
    int run = 0;
    int max_run = 0;
    int last_acc = -10;
    int exp_frames = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: pops one expectation per accepted word
    always @(negedge clk) begin
        if (o_overrun) ovr_seen = ovr_seen + 1;
        if (rst_n && o_valid && i_ready) begin
            if (last_acc == cyc - 1) run = run + 1;
            else run = 1;
            if (run > max_run) max_run = run;
            last_acc = cyc;
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_word idx=%0d word=%h", o_matrix_idx, o_word);
            end else begin
                e = sb.pop_front();
                if (o_word !== e.word || o_matrix_idx !== e.idx || o_last !== e.last ||
                    o_len_err !== e.len_err || o_addr !== e.word[11:8] || o_data !== e.word[7:0]) begin
                    errors = errors + 1;
                    $display("FAIL stream_word actual idx=%0d word=%h addr=%h data=%h last=%b len_err=%b required idx=%0d word=%h last=%b len_err=%b",
                             o_matrix_idx, o_word, o_addr, o_data, o_last, o_len_err,
                             e.idx, e.word, e.last, e.len_err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        sdin = b;
        tick(4);
        sclk = 1'b1;
        tb_sr = {tb_sr[126:0], b};
        tick(4);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input fvec_t fv, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit(fv.w[i / 16][15 - (i % 16)]);
        end
    endtask

    task automatic push_frame(input logic le);
        for (int k = 0; k < 8; k++) begin
            sb.push_back('{word: tb_sr[16*k +: 16], idx: 3'(k), last: (k == 7), len_err: le});
        end
        exp_frames = exp_frames + 1;
    endtask

    task automatic load_pulse(input bit accept, input logic le);
        sload = 1'b1;
        if (accept) push_frame(le);
        tick(4);
        sload = 1'b0;
        tick(4);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((o_valid || sb.size() != 0) && n < 300) begin
            tick(1);
            n++;
        end
        chk("drain_within_budget", 32'(n < 300), 32'd1);
    endtask

    // Stream with i_ready=1 until idx h is presented, then stall there
    task automatic hold_at(input int h);
        int n = 0;
        i_ready = 1'b1;
        while (!(o_valid && o_matrix_idx == 3'(h)) && n < 60) begin
            tick(1);
            n++;
        end
        i_ready = 1'b0;
        chk("hold_reached_idx", 32'(o_matrix_idx), 32'(h));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ovr_before;

        rst_n   = 1'b0;
        sclk    = 1'b0;
        sdin    = 1'b0;
        sload   = 1'b0;
        i_ready = 1'b0;
        tb_sr   = '0;

        vecs[0].w = '{16'h0C01, 16'h0B07, 16'h0900, 16'h0A08, 16'h0F01, 16'h0101, 16'h0203, 16'h0F00};
        vecs[0].nbits = 128; vecs[0].len_err = 1'b0; vecs[0].hold = -1;
        vecs[1].w = '{16'h01A5, 16'h01A5, 16'h01A5, 16'h01A5, 16'h01A5, 16'h01A5, 16'h01A5, 16'h01A5};
        vecs[1].nbits = 128; vecs[1].len_err = 1'b0; vecs[1].hold = 3;
        vecs[2].w = '{16'h0A55, 16'h05C3, 16'h0C3C, 16'h0781, 16'h0E7E, 16'h0399, 16'h0B66, 16'h0824};
        vecs[2].nbits = 120; vecs[2].len_err = 1'b1; vecs[2].hold = -1;
        vecs[3].w = '{16'h0112, 16'h0234, 16'h0356, 16'h0478, 16'h059A, 16'h06BC, 16'h07DE, 16'h08F0};
        vecs[3].nbits = 128; vecs[3].len_err = 1'b0; vecs[3].hold = -1;

        tick(3);
        chk("reset_flags", 32'({o_valid, o_busy, o_last, o_len_err, o_overrun}), 32'd0);
        chk("reset_word", 32'(o_word), 32'd0);
        chk("reset_idx", 32'(o_matrix_idx), 32'd0);
        chk("reset_frame_cnt", 32'(o_frame_cnt), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // Table-driven frames: normal, stalled, short, normal
        for (int v = 0; v < 4; v++) begin
            i_ready = (vecs[v].hold < 0);
            max_run = 0;
            send_bits(vecs[v], vecs[v].nbits);
            load_pulse(1'b1, vecs[v].len_err);
            if (vecs[v].hold >= 0) begin
                hold_at(vecs[v].hold);
                repeat (5) begin
                    tick(1);
                    chk("stall_valid", 32'(o_valid), 32'd1);
                    chk("stall_idx", 32'(o_matrix_idx), 32'(vecs[v].hold));
                    chk("stall_word", 32'(o_word), 32'(vecs[v].w[7 - vecs[v].hold]));
                end
                i_ready = 1'b1;
            end
            wait_drain();
            chk("frame_cnt", 32'(o_frame_cnt), 32'(exp_frames));
            if (vecs[v].hold < 0 && vecs[v].nbits == 128)
                chk("zero_bubble_run", 32'(max_run), 32'd8);
        end

        // Overrun: second LOAD while stalled at idx 2
        i_ready = 1'b0;
        send_bits(vecs[0], 128);
        load_pulse(1'b1, 1'b0);
        hold_at(2);
        ovr_before = ovr_seen;
        load_pulse(1'b0, 1'b0);
        tick(2);
        chk("overrun_pulse_count", 32'(ovr_seen - ovr_before), 32'd1);
        chk("overrun_frame_cnt", 32'(o_frame_cnt), 32'(exp_frames));
        chk("overrun_still_busy", 32'({o_busy, o_matrix_idx}), 32'({1'b1, 3'd2}));
        i_ready = 1'b1;
        wait_drain();

        // Coincident CLK and LOAD rising edges on bit 128 (bit value 1)
        send_bits(vecs[2], 127);
        sdin = 1'b1;
        tick(4);
        sclk  = 1'b1;
        sload = 1'b1;
        tb_sr = {tb_sr[126:0], 1'b1};
        push_frame(1'b0);
        tick(4);
        sclk  = 1'b0;
        sload = 1'b0;
        tick(4);
        wait_drain();
        chk("coincident_frame_cnt", 32'(o_frame_cnt), 32'(exp_frames));

        // Reset during EMIT at idx 4
        i_ready = 1'b0;
        send_bits(vecs[3], 128);
        load_pulse(1'b1, 1'b0);
        hold_at(4);
        rst_n = 1'b0;
        tick(1);
        chk("midreset_flags", 32'({o_valid, o_busy, o_last, o_len_err, o_overrun}), 32'd0);
        chk("midreset_word", 32'({o_word, o_addr, o_data}), 32'd0);
        chk("midreset_idx", 32'(o_matrix_idx), 32'd0);
        chk("midreset_frame_cnt", 32'(o_frame_cnt), 32'd0);
        sb.delete();
        exp_frames = 0;
        tb_sr = '0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        i_ready = 1'b1;
        send_bits(vecs[0], 128);
        load_pulse(1'b1, 1'b0);
        wait_drain();
        chk("post_reset_frame_cnt", 32'(o_frame_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
